// File: rtl/clock_set_sequencer_pkg.sv
// rtl/clock_set_sequencer_pkg.sv - timing constants, domain/field codes, state and press-event encodings
package clock_set_sequencer_pkg;

  localparam int LONG_TICKS    = 100;
  localparam int REPEAT_DELAY  = 50;
  localparam int REPEAT_PERIOD = 10;
  localparam int TIMEOUT_TICKS = 1000;
  localparam int BLINK_TICKS   = 25;

  localparam logic [1:0] DOM_TIME = 2'd0;
  localparam logic [1:0] DOM_DATE = 2'd1;
  localparam logic [1:0] DOM_ALM  = 2'd2;
  localparam logic [1:0] DOM_NONE = 2'd3;

  localparam logic [2:0] FLD_NONE = 3'b000;
  localparam logic [2:0] FLD_A    = 3'b100;
  localparam logic [2:0] FLD_B    = 3'b010;
  localparam logic [2:0] FLD_C    = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SET_A  = 3'd2,
    ST_SET_B  = 3'd3,
    ST_SET_C  = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_PRESS  = 3'd1,
    EV_SHORT  = 3'd2,
    EV_LONG   = 3'd3,
    EV_REPEAT = 3'd4
  } press_ev_t;

  function automatic logic [2:0] field_of(input state_t s);
    case (s)
      ST_SET_A: return FLD_A;
      ST_SET_B: return FLD_B;
      ST_SET_C: return FLD_C;
      default:  return FLD_NONE;
    endcase
  endfunction

  function automatic logic in_set(input state_t s);
    return (s == ST_SET_A) || (s == ST_SET_B) || (s == ST_SET_C);
  endfunction

endpackage

// File: rtl/clock_set_sequencer_press_timer.sv
// rtl/clock_set_sequencer_press_timer.sv - per-button edge detect, saturating hold counter, press events
// Auto-repeat strobes exist only when SET_AUTO_REPEAT_EN is defined.
module clock_set_sequencer_press_timer
  import clock_set_sequencer_pkg::*;
#(
  parameter bit LONG_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_btn,
  output logic       o_edge,
  output logic [2:0] o_ev
);

  localparam int HW = $clog2(LONG_TICKS + 1);

  logic          r_btn_d;
  logic [HW-1:0] r_hold_cnt;
  logic          w_rise, w_fall, w_long, w_rep;

  assign w_rise = i_btn & ~r_btn_d;
  assign w_fall = ~i_btn & r_btn_d;
  assign w_long = LONG_EN & i_btn & i_tick & (r_hold_cnt == HW'(LONG_TICKS - 1));
  assign o_edge = w_rise | w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_d    <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_btn_d <= i_btn;
      if (!i_btn)
        r_hold_cnt <= '0;
      else if (i_tick && r_hold_cnt != HW'(LONG_TICKS))
        r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

`ifdef SET_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  logic [RW-1:0] r_rep_cnt;

  assign w_rep = i_btn & i_tick & (r_rep_cnt == RW'(REPEAT_DELAY - 1));

  // Reloading below the threshold turns the initial delay into a fixed period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rep_cnt <= '0;
    else if (!i_btn)
      r_rep_cnt <= '0;
    else if (i_tick)
      r_rep_cnt <= w_rep ? RW'(REPEAT_DELAY - REPEAT_PERIOD) : r_rep_cnt + 1'b1;
  end
`else
  assign w_rep = 1'b0;
`endif

  // Long outranks repeat so a held mode button still cancels at the long threshold.
  always_comb begin
    o_ev = EV_NONE;
    if (w_rise)
      o_ev = EV_PRESS;
    else if (w_fall && r_hold_cnt < HW'(LONG_TICKS))
      o_ev = EV_SHORT;
    else if (w_long)
      o_ev = EV_LONG;
    else if (w_rep)
      o_ev = EV_REPEAT;
  end

endmodule

// File: rtl/clock_set_sequencer.sv
// rtl/clock_set_sequencer.sv - field-by-field set sequencer for clock/date/alarm from two buttons
// Build option SET_AUTO_REPEAT_EN enables held-adv auto-repeat increments.
module clock_set_sequencer
  import clock_set_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_adv,
  input  logic [1:0] i_domain,
  output logic       o_mode_short,
  output logic       o_reg_load,
  output logic [2:0] o_field,
  output logic [2:0] o_inc_en,
  output logic       o_commit,
  output logic       o_abort,
  output logic [1:0] o_commit_domain,
  output logic       o_busy,
  output logic       o_blink
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  state_t        r_state, w_state_nxt;
  logic [2:0]    w_mode_ev, w_adv_ev;
  logic          w_mode_edge, w_adv_edge;
  logic          w_short, w_long, w_adv_inc, w_timeout;
  logic [TW-1:0] r_to_cnt;
  logic [BW-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic          w_mode_short_nxt, w_abort_nxt, w_blink_nxt;
  logic [2:0]    w_inc_nxt;
  logic          r_mode_short, r_reg_load, r_commit, r_abort, r_busy, r_blink;
  logic [2:0]    r_field, r_inc_en;
  logic [1:0]    r_commit_domain;

  clock_set_sequencer_press_timer #(.LONG_EN(1'b1)) u_mode_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_tick (i_tick),
    .i_btn  (i_btn_mode),
    .o_edge (w_mode_edge),
    .o_ev   (w_mode_ev)
  );

  clock_set_sequencer_press_timer #(.LONG_EN(1'b0)) u_adv_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_tick (i_tick),
    .i_btn  (i_btn_adv),
    .o_edge (w_adv_edge),
    .o_ev   (w_adv_ev)
  );

  assign w_short   = (w_mode_ev == EV_SHORT);
  assign w_long    = (w_mode_ev == EV_LONG);
  assign w_adv_inc = (w_adv_ev == EV_PRESS) || (w_adv_ev == EV_REPEAT);
  assign w_timeout = in_set(r_state) && i_tick && !w_mode_edge && !w_adv_edge &&
                     (r_to_cnt == TW'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_mode_short_nxt = 1'b0;
    w_abort_nxt      = 1'b0;
    w_inc_nxt        = '0;
    w_blink_nxt      = r_blink;
    w_blink_cnt_nxt  = r_blink_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_short)
          w_mode_short_nxt = 1'b1;
        else if (w_long && i_domain != DOM_NONE)
          w_state_nxt = ST_LOAD;
      end
      ST_LOAD: w_state_nxt = ST_SET_A;
      ST_SET_A, ST_SET_B, ST_SET_C: begin
        // Mode events outrank a coincident adv edge, which is simply dropped.
        if (w_long) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = 1'b1;
        end else if (w_short) begin
          if (r_state == ST_SET_A)
            w_state_nxt = ST_SET_B;
          else if (r_state == ST_SET_B && r_commit_domain != DOM_ALM)
            w_state_nxt = ST_SET_C;
          else
            w_state_nxt = ST_COMMIT;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = 1'b1;
        end else if (w_adv_inc) begin
          w_inc_nxt = r_field;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase

    if (!in_set(w_state_nxt)) begin
      w_blink_nxt     = 1'b0;
      w_blink_cnt_nxt = '0;
    end else if (w_state_nxt != r_state) begin
      w_blink_nxt     = 1'b1;
      w_blink_cnt_nxt = '0;
    end else if (i_tick) begin
      if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
        w_blink_nxt     = ~r_blink;
        w_blink_cnt_nxt = '0;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_short    <= 1'b0;
      r_reg_load      <= 1'b0;
      r_field         <= '0;
      r_inc_en        <= '0;
      r_commit        <= 1'b0;
      r_abort         <= 1'b0;
      r_commit_domain <= '0;
      r_busy          <= 1'b0;
      r_blink         <= 1'b0;
      r_blink_cnt     <= '0;
      r_to_cnt        <= '0;
    end else begin
      r_mode_short <= w_mode_short_nxt;
      r_reg_load   <= (w_state_nxt == ST_LOAD);
      r_field      <= field_of(w_state_nxt);
      r_inc_en     <= w_inc_nxt;
      r_commit     <= (w_state_nxt == ST_COMMIT);
      r_abort      <= w_abort_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_blink      <= w_blink_nxt;
      r_blink_cnt  <= w_blink_cnt_nxt;
      if (r_state == ST_IDLE && w_state_nxt == ST_LOAD)
        r_commit_domain <= i_domain;
      if (!in_set(r_state) || w_mode_edge || w_adv_edge)
        r_to_cnt <= '0;
      else if (i_tick)
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign o_mode_short    = r_mode_short;
  assign o_reg_load      = r_reg_load;
  assign o_field         = r_field;
  assign o_inc_en        = r_inc_en;
  assign o_commit        = r_commit;
  assign o_abort         = r_abort;
  assign o_commit_domain = r_commit_domain;
  assign o_busy          = r_busy;
  assign o_blink         = r_blink;

endmodule
